// File: rtl/way_select_ctrl.sv
// Data-way mux select sequencer with one set's tree pseudo-LRU replacement state.
// Optional saturating hit/miss statistics are built only with WAY_SELECT_STATS_EN defined.
module way_select_ctrl #(
  parameter int unsigned WAYS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     lookup_valid,
  output logic                     lookup_ready,
  input  logic [WAYS-1:0]          hit_vec,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(WAYS)-1:0]  select,
  output logic                     hit,
  output logic                     multi_hit,
  input  logic                     fill_done,
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count
);

  localparam int unsigned SEL_W = $clog2(WAYS);
  localparam int unsigned NODES = WAYS - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    FILL = 2'd2
  } state_e;

  state_e             state;
  logic [NODES-1:0]   plru;
  logic [SEL_W-1:0]   victim_c;
  logic [SEL_W-1:0]   lowest_c;
  logic [NODES-1:0]   plru_touched_c;
  logic               any_hit_c;
  logic               multi_c;
  logic               accept_c;
  logic               resp_hs_c;

  // Walk from the root; a node bit of 0 sends the victim into the lower half.
  function automatic logic [SEL_W-1:0] plru_victim(input logic [NODES-1:0] t);
    logic [SEL_W-1:0] w;
    logic [NODES-1:0] sh;
    int unsigned      node;
    w    = '0;
    node = 0;
    for (int unsigned l = 0; l < SEL_W; l++) begin
      sh   = t >> node;
      w    = SEL_W'({w, sh[0]});
      node = 2 * node + 1 + 32'(sh[0]);
    end
    return w;
  endfunction

  // Point every node on the accessed way's path away from that way.
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] t,
                                                  input logic [SEL_W-1:0] w);
    logic [NODES-1:0] r;
    logic [SEL_W-1:0] ws;
    int unsigned      node;
    r    = t;
    node = 0;
    for (int unsigned l = 0; l < SEL_W; l++) begin
      ws   = w >> (SEL_W - 1 - l);
      r    = (r & ~(NODES'(1) << node)) | (NODES'(!ws[0]) << node);
      node = 2 * node + 1 + 32'(ws[0]);
    end
    return r;
  endfunction

  always_comb begin
    logic [WAYS-1:0] tmp;
    lowest_c = '0;
    tmp      = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      tmp = hit_vec >> i;
      if (tmp[0]) lowest_c = SEL_W'(i);
    end
  end

  assign any_hit_c      = |hit_vec;
  assign multi_c        = |(hit_vec & (hit_vec - WAYS'(1)));
  assign victim_c       = plru_victim(plru);
  assign plru_touched_c = plru_touch(plru, select);
  assign accept_c       = lookup_valid & lookup_ready;
  assign resp_hs_c      = resp_valid & resp_ready;

  // Control FSM; select/hit/multi_hit are captured at acceptance and held until IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      plru         <= '0;
      select       <= '0;
      hit          <= 1'b0;
      multi_hit    <= 1'b0;
      resp_valid   <= 1'b0;
      lookup_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          lookup_ready <= 1'b1;
          if (accept_c) begin
            hit          <= any_hit_c;
            multi_hit    <= multi_c;
            select       <= any_hit_c ? lowest_c : victim_c;
            resp_valid   <= 1'b1;
            lookup_ready <= 1'b0;
            state        <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            if (hit) begin
              plru         <= plru_touched_c;
              lookup_ready <= 1'b1;
              state        <= IDLE;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (fill_done) begin
            plru         <= plru_touched_c;
            lookup_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          resp_valid   <= 1'b0;
          lookup_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef WAY_SELECT_STATS_EN
  // Saturating counters, stepped once per response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (resp_hs_c) begin
      if (hit && hit_count != 16'hFFFF)    hit_count  <= hit_count + 16'd1;
      if (!hit && miss_count != 16'hFFFF)  miss_count <= miss_count + 16'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
